// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: word-addressed PC, single-outstanding req/ack memory port,
// and a small prefetch queue feeding decode. A redirect flushes the queue and refetches.
module if_fetch_unit #(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 16,
    parameter int              DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              ready,
    input  logic              take
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic              push;
    logic              pop;

    // Fetch FSM next state. A request in flight when a redirect arrives is parked in
    // DROP so its late response can be swallowed without stalling the new PC update.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!redirect && (count_q < CNT_W'(DEPTH))) state_d = WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    state_d     = imem_ack ? IDLE : DROP;
                    drop_addr_d = fetch_pc_q;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                    state_d    = IDLE;
                end
            end
            DROP: begin
                if (imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (redirect) fetch_pc_d = redirect_pc;
    end

    // Queue bookkeeping; redirect wins over both push and pop.
    always_comb begin
        pop     = take && (count_q != '0) && !redirect;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // NOTE: queue storage has no reset; entries are only visible when count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[tail_q] <= imem_rdata;
            pc_mem_q[tail_q]   <= fetch_pc_q;
        end
    end

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
    assign ready     = (count_q != '0);
    assign inst_out  = ready ? inst_mem_q[head_q] : '0;
    assign pc_out    = ready ? pc_mem_q[head_q] : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a cycle-by-cycle vector table for streaming,
// stalls, redirects and wrap, plus hand sequences for late-ack drop and mid-run reset.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] inst_out;
    logic [15:0] pc_out;
    logic        ready;
    logic        take;

    int checks = 0;
    int errors = 0;

    if_fetch_unit #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(2), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_out(inst_out), .pc_out(pc_out), .ready(ready),
        .take(take)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        red;
        logic [15:0] rpc;
        logic        ack;
        logic [15:0] rdata;
        logic        tk;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_ready;
        logic [15:0] e_inst;
        logic [15:0] e_pc;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic red, logic [15:0] rpc, logic ack, logic [15:0] rdata,
                                logic tk, logic e_req, logic [15:0] e_addr, logic e_ready,
                                logic [15:0] e_inst, logic [15:0] e_pc);
        vec_t v;
        v.red = red; v.rpc = rpc; v.ack = ack; v.rdata = rdata; v.tk = tk;
        v.e_req = e_req; v.e_addr = e_addr; v.e_ready = e_ready;
        v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [15:0] e_addr,
                                 input logic e_ready, input logic [15:0] e_inst,
                                 input logic [15:0] e_pc);
        check({tag, "_req"},   32'(imem_req),  32'(e_req));
        check({tag, "_addr"},  32'(imem_addr), 32'(e_addr));
        check({tag, "_ready"}, 32'(ready),     32'(e_ready));
        check({tag, "_inst"},  32'(inst_out),  32'(e_inst));
        check({tag, "_pc"},    32'(pc_out),    32'(e_pc));
    endtask

    initial begin
        int n;

        //        red  rpc       ack rdata    tk | req addr     rdy inst     pc
        vecs[0]  = mk(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        vecs[1]  = mk(0, 16'h0000, 1, 16'h2000, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        vecs[2]  = mk(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0001, 1, 16'h2000, 16'h0000);
        vecs[3]  = mk(0, 16'h0000, 1, 16'h2001, 1, 1, 16'h0001, 0, 16'h0000, 16'h0000);
        vecs[4]  = mk(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0002, 1, 16'h2001, 16'h0001);
        vecs[5]  = mk(0, 16'h0000, 1, 16'h2002, 1, 1, 16'h0002, 0, 16'h0000, 16'h0000);
        vecs[6]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0003, 1, 16'h2002, 16'h0002);
        vecs[7]  = mk(0, 16'h0000, 1, 16'h2003, 0, 1, 16'h0003, 1, 16'h2002, 16'h0002);
        vecs[8]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h2002, 16'h0002);
        vecs[9]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h2002, 16'h0002);
        vecs[10] = mk(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0004, 1, 16'h2002, 16'h0002);
        vecs[11] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h2003, 16'h0003);
        vecs[12] = mk(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0004, 1, 16'h2003, 16'h0003);
        vecs[13] = mk(0, 16'h0000, 1, 16'h2004, 1, 1, 16'h0004, 1, 16'h2003, 16'h0003);
        vecs[14] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0005, 1, 16'h2004, 16'h0004);
        vecs[15] = mk(1, 16'h0100, 1, 16'h2005, 1, 1, 16'h0005, 1, 16'h2004, 16'h0004);
        vecs[16] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0100, 0, 16'h0000, 16'h0000);
        vecs[17] = mk(0, 16'h0000, 1, 16'h2100, 0, 1, 16'h0100, 0, 16'h0000, 16'h0000);
        vecs[18] = mk(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0101, 1, 16'h2100, 16'h0100);
        vecs[19] = mk(1, 16'h0200, 0, 16'h0000, 0, 1, 16'h0101, 0, 16'h0000, 16'h0000);
        vecs[20] = mk(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0101, 0, 16'h0000, 16'h0000);
        vecs[21] = mk(1, 16'hFFFF, 0, 16'h0000, 0, 1, 16'h0101, 0, 16'h0000, 16'h0000);
        vecs[22] = mk(0, 16'h0000, 1, 16'h2101, 0, 1, 16'h0101, 0, 16'h0000, 16'h0000);
        vecs[23] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'hFFFF, 0, 16'h0000, 16'h0000);
        vecs[24] = mk(0, 16'h0000, 1, 16'h3FFF, 0, 1, 16'hFFFF, 0, 16'h0000, 16'h0000);
        vecs[25] = mk(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h3FFF, 16'hFFFF);
        vecs[26] = mk(0, 16'h0000, 1, 16'h3000, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        vecs[27] = mk(1, 16'h0030, 0, 16'h0000, 1, 0, 16'h0001, 1, 16'h3000, 16'h0000);
        vecs[28] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0030, 0, 16'h0000, 16'h0000);
        vecs[29] = mk(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0030, 0, 16'h0000, 16'h0000);

        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        take        = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("rst", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        reset = 1'b0;

        // Outputs are checked against the state left by the previous edge, then the
        // vector's inputs are driven for the coming edge.
        for (int i = 0; i < NVEC; i++) begin
            check_outputs($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr,
                          vecs[i].e_ready, vecs[i].e_inst, vecs[i].e_pc);
            redirect    = vecs[i].red;
            redirect_pc = vecs[i].rpc;
            imem_ack    = vecs[i].ack;
            imem_rdata  = vecs[i].rdata;
            take        = vecs[i].tk;
            @(negedge clk);
        end
        redirect = 1'b0; imem_ack = 1'b0; take = 1'b0;

        // Redirect one cycle after request issue, ack latency 3: late data must be dropped.
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        check_outputs("t4_drop", 1'b1, 16'h0030, 1'b0, 16'h0000, 16'h0000);
        imem_ack   = 1'b1;
        imem_rdata = 16'hDEAD;
        @(negedge clk);
        imem_ack = 1'b0;
        check_outputs("t4_idle", 1'b0, 16'h0040, 1'b0, 16'h0000, 16'h0000);
        n = 0;
        while (!imem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("t4_req_issued", 32'(imem_req), 32'(1));
        check("t4_req_addr", 32'(imem_addr), 32'h0040);
        check("t4_not_ready", 32'(ready), 32'(0));
        imem_ack   = 1'b1;
        imem_rdata = 16'h2040;
        @(negedge clk);
        imem_ack = 1'b0;
        n = 0;
        while (!ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("t4_ready", 32'(ready), 32'(1));
        check("t4_inst", 32'(inst_out), 32'h2040);
        check("t4_pc", 32'(pc_out), 32'h0040);

        // Mid-run asynchronous reset with a non-empty queue and a request in flight.
        @(negedge clk);
        check("t1_pre_req", 32'(imem_req), 32'(1));
        check("t1_pre_addr", 32'(imem_addr), 32'h0041);
        #2 reset = 1'b1;
        #1;
        check_outputs("t1_rst", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t1_next_req", 32'(imem_req), 32'(1));
        check("t1_next_addr", 32'(imem_addr), 32'h0000);
        check("t1_ready", 32'(ready), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
